sprite_palette: RTL and testbench

SPRITE_PALETTE -- requirements
Module: sprite_palette

---
 rtl/sprite_palette_pkg.sv | 39 +++
 rtl/palette_port.sv | 59 +++++
 rtl/sprite_palette.sv | 133 +++++++++++++
 tb/tb_sprite_palette.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_palette_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sprite_palette_pkg
// Brief    : Shared types, default palette contents and colour helpers.
// Revision : 1.0 - initial release
// ============================================================================
package sprite_palette_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RESTORE = 1'b1
    } state_t;

    localparam rgb12_t [0:15] DEFAULT_PALETTE = {
        12'h7DF, 12'hFFF, 12'hEEE, 12'h48A,
        12'hBDD, 12'hFFF, 12'h4BF, 12'hFFF,
        12'hADF, 12'h8AB, 12'h7DF, 12'h6CF,
        12'h39C, 12'hACD, 12'hEEE, 12'hEEE
    };

    // Larger tables repeat the 16-entry pattern.
    function automatic rgb12_t default_entry(input logic [3:0] idx);
        return DEFAULT_PALETTE[idx];
    endfunction

    function automatic logic [3:0] sat_add(input logic [3:0] c, input logic [4:0] step);
        logic [4:0] sum;
        sum = {1'b0, c} + step;
        return (sum > 5'd15) ? 4'hF : sum[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/palette_port.sv
`default_nettype none
// ============================================================================
// Module   : palette_port
// Brief    : One read channel: highlight saturation, blink blanking, output reg.
// Revision : 1.0 - initial release
// ============================================================================
module palette_port
    import sprite_palette_pkg::*;
#(
    parameter int HL_STEP = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rd_en,
    input  logic       highlight,
    input  logic       blink,
    input  logic       blink_phase,
    input  rgb12_t     entry,
    output logic       rd_valid,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue
);

    rgb12_t w_hl;
    rgb12_t w_out;
    rgb12_t r_rgb;
    logic   r_valid;

    // Blanking is applied after highlight so a blinking entry goes fully dark.
    always_comb begin
        w_hl = entry;
        if (highlight) begin
            w_hl.r = sat_add(entry.r, 5'(HL_STEP));
            w_hl.g = sat_add(entry.g, 5'(HL_STEP));
            w_hl.b = sat_add(entry.b, 5'(HL_STEP));
        end
        w_out = (blink && blink_phase) ? '0 : w_hl;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_rgb   <= '0;
        end else begin
            r_valid <= rd_en;
            if (rd_en) begin
                r_rgb <= w_out;
            end
        end
    end

    assign rd_valid = r_valid;
    assign red      = r_rgb.r;
    assign green    = r_rgb.g;
    assign blue     = r_rgb.b;

endmodule
`default_nettype wire

// File: rtl/sprite_palette.sv
`default_nettype none
// ============================================================================
// Module   : sprite_palette
// Brief    : Multi-port sprite palette with restore FSM; blink via SPRITE_PALETTE_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_palette
    import sprite_palette_pkg::*;
#(
    parameter int INDEX_W      = 4,
    parameter int NUM_PORTS    = 2,
    parameter int HL_STEP      = 3,
    parameter int BLINK_PERIOD = 25_000_000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic [INDEX_W-1:0]                wr_index,
    input  logic [11:0]                       wr_rgb,
    input  logic                              restore,
    output logic                              busy,
    input  logic [NUM_PORTS-1:0]              rd_en,
    input  logic [NUM_PORTS-1:0][INDEX_W-1:0] rd_index,
    input  logic [NUM_PORTS-1:0]              highlight,
    input  logic [NUM_PORTS-1:0]              blink,
    output logic [NUM_PORTS-1:0]              rd_valid,
    output logic [NUM_PORTS-1:0][3:0]         red,
    output logic [NUM_PORTS-1:0][3:0]         green,
    output logic [NUM_PORTS-1:0][3:0]         blue
);

    localparam int ENTRIES = 2 ** INDEX_W;

    rgb12_t             r_table [ENTRIES];
    state_t             r_state;
    state_t             w_state_nxt;
    logic [INDEX_W-1:0] r_rst_idx;
    logic [INDEX_W-1:0] w_rst_idx_nxt;
    logic               w_last;
    logic               w_phase;

    assign w_last = (r_rst_idx == INDEX_W'(ENTRIES - 1));

    always_comb begin
        w_state_nxt   = r_state;
        w_rst_idx_nxt = r_rst_idx;
        case (r_state)
            ST_IDLE: begin
                if (restore) begin
                    w_state_nxt   = ST_RESTORE;
                    w_rst_idx_nxt = '0;
                end
            end
            ST_RESTORE: begin
                w_rst_idx_nxt = r_rst_idx + INDEX_W'(1);
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rst_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rst_idx <= w_rst_idx_nxt;
        end
    end

    // Restore owns the write path; an external write in the pulse cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= default_entry(4'(i));
            end
        end else if (r_state == ST_RESTORE) begin
            r_table[r_rst_idx] <= default_entry(4'(r_rst_idx));
        end else if (wr_en && !restore) begin
            r_table[wr_index] <= wr_rgb;
        end
    end

    assign busy = (r_state == ST_RESTORE);

`ifdef SPRITE_PALETTE_BLINK_EN
    localparam int CNT_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

    logic [CNT_W-1:0] r_blink_cnt;
    logic             r_blink_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == CNT_W'(BLINK_PERIOD - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + CNT_W'(1);
        end
    end

    assign w_phase = r_blink_phase;
`else
    logic [31:0] w_unused_period;
    assign w_unused_period = BLINK_PERIOD;
    assign w_phase         = 1'b0;
`endif

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        palette_port #(
            .HL_STEP (HL_STEP)
        ) u_port (
            .clk         (clk),
            .rst         (rst),
            .rd_en       (rd_en[p]),
            .highlight   (highlight[p]),
            .blink       (blink[p]),
            .blink_phase (w_phase),
            .entry       (r_table[rd_index[p]]),
            .rd_valid    (rd_valid[p]),
            .red         (red[p]),
            .green       (green[p]),
            .blue        (blue[p])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_palette.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_palette
// Brief    : Randomised + directed self-checking bench for sprite_palette.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_palette;

    localparam int NP = 2;
    localparam int BP = 4;
    localparam int HL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, wr_en, restore, busy;
    logic [3:0]           wr_index;
    logic [11:0]          wr_rgb;
    logic [NP-1:0]        rd_en, highlight, blink, rd_valid;
    logic [NP-1:0][3:0]   rd_index, red, green, blue;

    sprite_palette #(
        .INDEX_W      (4),
        .NUM_PORTS    (NP),
        .HL_STEP      (HL),
        .BLINK_PERIOD (BP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_index  (wr_index),
        .wr_rgb    (wr_rgb),
        .restore   (restore),
        .busy      (busy),
        .rd_en     (rd_en),
        .rd_index  (rd_index),
        .highlight (highlight),
        .blink     (blink),
        .rd_valid  (rd_valid),
        .red       (red),
        .green     (green),
        .blue      (blue)
    );

    int vectors    = 0;
    int miscompares = 0;

    logic [11:0] defs [16] = '{12'h7DF, 12'hFFF, 12'hEEE, 12'h48A, 12'hBDD, 12'hFFF,
                               12'h4BF, 12'hFFF, 12'hADF, 12'h8AB, 12'h7DF, 12'h6CF,
                               12'h39C, 12'hACD, 12'hEEE, 12'hEEE};

`ifdef SPRITE_PALETTE_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    // Reference model state
    logic [11:0]   tbl [16];
    bit            restoring;
    int            ridx;
    bit [NP-1:0]   exp_valid;
    logic [11:0]   exp_rgb [NP];
    bit            exp_busy;
    int            bcnt;
    bit            bphase;
    bit            model_ok = 1'b0;

    function automatic logic [11:0] brighten(input logic [11:0] v);
        int c [3];
        logic [11:0] o;
        c[0] = int'(v[11:8]) + HL;
        c[1] = int'(v[7:4]) + HL;
        c[2] = int'(v[3:0]) + HL;
        for (int k = 0; k < 3; k++) if (c[k] > 15) c[k] = 15;
        o = {4'(c[0]), 4'(c[1]), 4'(c[2])};
        return o;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) tbl[i] = defs[i];
            restoring = 1'b0;
            ridx      = 0;
            exp_valid = '0;
            for (int p = 0; p < NP; p++) exp_rgb[p] = '0;
            exp_busy  = 1'b0;
            bcnt      = 0;
            bphase    = 1'b0;
            model_ok  = 1'b1;
        end else begin
            for (int p = 0; p < NP; p++) begin
                logic [11:0] v;
                exp_valid[p] = rd_en[p];
                if (rd_en[p]) begin
                    v = tbl[rd_index[p]];
                    if (highlight[p]) v = brighten(v);
                    if (BLINK_ON && blink[p] && bphase) v = 12'h000;
                    exp_rgb[p] = v;
                end
            end
            if (restoring) begin
                tbl[ridx] = defs[ridx];
                ridx++;
                if (ridx == 16) restoring = 1'b0;
            end else if (restore) begin
                restoring = 1'b1;
                ridx      = 0;
            end else if (wr_en) begin
                tbl[wr_index] = wr_rgb;
            end
            exp_busy = restoring;
            bcnt++;
            if (bcnt == BP) begin
                bcnt   = 0;
                bphase = ~bphase;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            vectors++;
            if (busy !== exp_busy) begin
                miscompares++;
                $display("FAIL busy t=%0t got=%b want=%b", $time, busy, exp_busy);
            end
            for (int p = 0; p < NP; p++) begin
                vectors++;
                if (rd_valid[p] !== exp_valid[p] || {red[p], green[p], blue[p]} !== exp_rgb[p]) begin
                    miscompares++;
                    $display("FAIL port%0d t=%0t got valid=%b rgb=%h want valid=%b rgb=%h",
                             p, $time, rd_valid[p], {red[p], green[p], blue[p]},
                             exp_valid[p], exp_rgb[p]);
                end
            end
        end
    end

    task automatic expect_lit(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; wr_en = 1'b0; restore = 1'b0; wr_index = '0; wr_rgb = '0;
        rd_en = '0; rd_index = '0; highlight = '0; blink = '0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    function automatic logic [11:0] port_rgb(input int p);
        return {red[p], green[p], blue[p]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        idle_inputs();
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        expect_lit("reset_busy", 32'(busy), 0);
        expect_lit("reset_valid", 32'(rd_valid), 0);
        expect_lit("reset_rgb0", 32'(port_rgb(0)), 0);

        rd_en[0] = 1'b1; rd_index[0] = 4'd3;
        cyc();
        expect_lit("read3_valid", 32'(rd_valid[0]), 1);
        expect_lit("read3_rgb", 32'(port_rgb(0)), 32'h48A);
        rd_en[0] = 1'b0; rd_index[0] = 4'd7;
        cyc();
        expect_lit("hold_valid", 32'(rd_valid[0]), 0);
        expect_lit("hold_rgb", 32'(port_rgb(0)), 32'h48A);

        rd_en[0] = 1'b1; rd_index[0] = 4'd0; highlight[0] = 1'b1;
        cyc();
        expect_lit("highlight0", 32'(port_rgb(0)), 32'hAFF);
        idle_inputs();

        wr_en = 1'b1; wr_index = 4'd5; wr_rgb = 12'h123;
        rd_en[1] = 1'b1; rd_index[1] = 4'd5;
        cyc();
        expect_lit("rw_same_cycle", 32'(port_rgb(1)), 32'hFFF);
        wr_en = 1'b0;
        cyc();
        expect_lit("rw_reread", 32'(port_rgb(1)), 32'h123);
        idle_inputs();

        // Clear table, then restore with writes held on throughout
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_index = 4'(i); wr_rgb = 12'h000;
            cyc();
        end
        restore = 1'b1; wr_index = 4'd9; wr_rgb = 12'h555;
        cyc();
        restore = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            restore  = (n == 3);
            wr_index = 4'($urandom_range(0, 15));
            wr_rgb   = 12'($urandom);
            rd_en    = 2'($urandom); rd_index = 8'($urandom);
            cyc();
        end
        expect_lit("restore_busy_cycles", 32'(n), 16);
        idle_inputs();
        rd_en[0] = 1'b1; rd_index[0] = 4'd0;
        rd_en[1] = 1'b1; rd_index[1] = 4'd13;
        cyc();
        expect_lit("restored_entry0", 32'(port_rgb(0)), 32'h7DF);
        expect_lit("restored_entry13", 32'(port_rgb(1)), 32'hACD);
        for (int i = 0; i < 16; i++) begin
            rd_index[0] = 4'(i); rd_index[1] = 4'(15 - i);
            cyc();
        end
        idle_inputs();

        // Reset aborts restore part way through
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_index = 4'(i); wr_rgb = 12'h111;
            cyc();
        end
        wr_en = 1'b0; restore = 1'b1;
        cyc();
        restore = 1'b0;
        for (int i = 0; i < 6; i++) cyc();
        expect_lit("busy_before_abort", 32'(busy), 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        expect_lit("busy_after_abort", 32'(busy), 0);
        rd_en[0] = 1'b1; rd_index[0] = 4'd12;
        cyc();
        expect_lit("abort_entry12", 32'(port_rgb(0)), 32'h39C);
        for (int i = 0; i < 16; i++) begin
            rd_index[0] = 4'(i); rd_index[1] = 4'(i ^ 5);
            rd_en[1] = 1'b1; highlight = 2'($urandom);
            cyc();
        end
        idle_inputs();

`ifdef SPRITE_PALETTE_BLINK_EN
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        rd_en[0] = 1'b1; rd_index[0] = 4'd1; blink[0] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            cyc();
            expect_lit("blink_pattern", 32'(port_rgb(0)), ((k / 4) % 2 == 1) ? 32'h000 : 32'hFFF);
        end
        idle_inputs();
`endif

        for (int k = 0; k < 600; k++) begin
            rst       = ($urandom_range(0, 99) == 0);
            restore   = ($urandom_range(0, 39) == 0);
            wr_en     = ($urandom_range(0, 9) < 3);
            wr_index  = 4'($urandom);
            wr_rgb    = 12'($urandom);
            rd_en     = 2'($urandom);
            rd_index  = 8'($urandom);
            highlight = 2'($urandom);
            blink     = 2'($urandom);
            cyc();
        end
        idle_inputs();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
